// File: rtl/seg7_dual_decoder.sv
// Receive-side decoder for a dual multiplexed seven-segment bus: tracks the digit
// select, decodes each phase back to BCD and filters over identical frames.
//
// state | meaning
// SYNC  | waiting for a rising select edge; no capture, no checks
// TENS  | inside the tens phase; falling edge captures the tens digit
// ONES  | inside the ones phase; rising edge captures the ones digit, ends a frame
module seg7_dual_decoder #(
    parameter int STABLE_FRAMES = 4,
    parameter int MIN_PHASE     = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] disp_in,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid,
    output logic       update,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_FRAMES + 1);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_TENS = 2'd1;
    localparam logic [1:0] S_ONES = 2'd2;

    logic [7:0]    d_q, d_qq;
    logic [CW-1:0] phase_cnt;
    logic [1:0]    state, state_n;
    logic [3:0]    cand_t, cand_o, prev_t, prev_o;
    logic          frame_done;
    logic [SW-1:0] stab_cnt, stab_next;

    logic       sel_edge, phase_ok, timeout_hit;
    logic [3:0] dec_val;
    logic       dec_ok;
    logic       cap_t, cap_o, err_n, clear_stab, pair_same, accept;

    assign sel_edge    = d_q[7] ^ d_qq[7];
    assign phase_ok    = phase_cnt >= CW'(MIN_PHASE);
    assign timeout_hit = !sel_edge && (phase_cnt == CW'(TIMEOUT));

    always_comb begin
        dec_val = 4'hF;
        dec_ok  = 1'b1;
        case (d_qq[6:0])
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            7'h00:   dec_val = 4'hF;
            default: dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cap_t   = 1'b0;
        cap_o   = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_SYNC: if (sel_edge && d_q[7]) state_n = S_TENS;
            S_TENS: begin
                if (sel_edge && !d_q[7]) begin
                    if (phase_ok && dec_ok) begin
                        cap_t   = 1'b1;
                        state_n = S_ONES;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_SYNC;
                    end
                end
            end
            S_ONES: begin
                if (sel_edge && d_q[7]) begin
                    if (phase_ok && dec_ok) begin
                        cap_o   = 1'b1;
                        state_n = S_TENS;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_SYNC;
                    end
                end
            end
            default: state_n = S_SYNC;
        endcase
        if (timeout_hit) state_n = S_SYNC;
    end

    assign clear_stab = err_n || timeout_hit || (state_n == S_SYNC && state != S_SYNC);
    assign pair_same  = {cand_t, cand_o} == {prev_t, prev_o};

    always_comb begin
        stab_next = SW'(1);
        if (pair_same) begin
            stab_next = (stab_cnt == SW'(STABLE_FRAMES)) ? stab_cnt : stab_cnt + SW'(1);
        end
    end

    // Accept only on the frame that first brings the count to STABLE_FRAMES.
    assign accept = frame_done && (stab_next == SW'(STABLE_FRAMES))
                    && (stab_cnt != SW'(STABLE_FRAMES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q        <= '0;
            d_qq       <= '0;
            phase_cnt  <= '0;
            state      <= S_SYNC;
            cand_t     <= 4'hF;
            cand_o     <= 4'hF;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            d_q        <= disp_in;
            d_qq       <= d_q;
            state      <= state_n;
            frame_done <= cap_o;
            err        <= err_n;
            if (sel_edge) phase_cnt <= CW'(1);
            else if (phase_cnt != CW'(TIMEOUT)) phase_cnt <= phase_cnt + CW'(1);
            if (cap_t) cand_t <= dec_val;
            if (cap_o) cand_o <= dec_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stab_cnt <= '0;
            prev_t   <= 4'hF;
            prev_o   <= 4'hF;
            tens     <= 4'hF;
            ones     <= 4'hF;
            valid    <= 1'b0;
            update   <= 1'b0;
        end else begin
            update <= 1'b0;
            if (clear_stab) stab_cnt <= '0;
            else if (frame_done) stab_cnt <= stab_next;
            if (frame_done) begin
                prev_t <= cand_t;
                prev_o <= cand_o;
            end
            if (accept) begin
                valid <= 1'b1;
                if ({cand_t, cand_o} != {tens, ones}) begin
                    tens   <= cand_t;
                    ones   <= cand_o;
                    update <= 1'b1;
                end
            end
            if (timeout_hit) valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_dual_decoder.sv
// Bench for seg7_dual_decoder: directed and random bus phases checked against a
// phase-level model of the decoding, filtering and timeout rules.
module tb_seg7_dual_decoder;

    localparam int SF      = 4;
    localparam int MINP    = 2;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] disp_in;
    logic [3:0] tens, ones;
    logic       valid, update, err;

    seg7_dual_decoder #(.STABLE_FRAMES(SF), .MIN_PHASE(MINP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .disp_in(disp_in),
        .tens(tens), .ones(ones), .valid(valid), .update(update), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    logic [6:0] pat_tab [0:10];
    initial begin
        pat_tab[0] = 7'h3F; pat_tab[1] = 7'h06; pat_tab[2] = 7'h5B; pat_tab[3] = 7'h4F;
        pat_tab[4] = 7'h66; pat_tab[5] = 7'h6D; pat_tab[6] = 7'h7D; pat_tab[7] = 7'h07;
        pat_tab[8] = 7'h7F; pat_tab[9] = 7'h6F; pat_tab[10] = 7'h00;
    end

    // Model state: waiting mode 0 = needs a rising select, 1 = next phase end is tens,
    // 2 = next phase end is ones.
    int m_mode, m_ct, m_run, m_prev, m_out, m_valid, exp_upd, exp_err;
    bit         cur_sel;
    logic [6:0] cur_pat;
    int         cur_len;

    function automatic int dec(logic [6:0] p);
        for (int i = 0; i < 11; i++)
            if (pat_tab[i] == p) return (i == 10) ? 15 : i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_prev = -1; m_out = 8'hFF; m_valid = 0;
    endtask

    task automatic model_fail();
        exp_err++; m_run = 0; m_mode = 0;
    endtask

    task automatic model_end(bit sel, logic [6:0] pat, int len);
        int v, pair, nr;
        bit ok;
        v  = dec(pat);
        ok = (v >= 0) && (len >= MINP);
        if (m_mode == 0) begin
            if (!sel) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ok) begin m_ct = v; m_mode = 2; end
            else model_fail();
        end else begin
            if (ok) begin
                pair = m_ct * 16 + v;
                nr = (pair == m_prev) ? ((m_run + 1 > SF) ? SF : m_run + 1) : 1;
                if (nr == SF && m_run != SF) begin
                    m_valid = 1;
                    if (pair != m_out) begin m_out = pair; exp_upd++; end
                end
                m_run = nr; m_prev = pair; m_mode = 1;
            end else model_fail();
        end
    endtask

    task automatic drive_phase(bit sel, logic [6:0] pat, int len);
        if (sel != cur_sel) begin
            model_end(cur_sel, cur_pat, cur_len);
            cur_sel = sel;
            cur_len = 0;
        end
        cur_pat = pat;
        for (int i = 0; i < len; i++) begin
            disp_in = {sel, pat};
            @(posedge clk);
            #1;
            cur_len++;
            if (cur_len > TIMEOUT) begin m_valid = 0; m_run = 0; m_mode = 0; end
        end
    endtask

    task automatic frames(logic [6:0] t, logic [6:0] o, int n);
        for (int i = 0; i < n; i++) begin
            drive_phase(1'b1, t, 2);
            drive_phase(1'b0, o, 2);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkpoint(string tag);
        drive_phase(cur_sel, cur_pat, 6);
        chk({tag, ".tens"}, 32'(tens), 32'((m_out >> 4) & 15));
        chk({tag, ".ones"}, 32'(ones), 32'(m_out & 15));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".updates"}, 32'(upd_cnt), 32'(exp_upd));
        chk({tag, ".errs"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        int t_i, o_i, reps, len;
        logic [6:0] tp, op;
        reset = 1'b1; disp_in = 8'h00;
        cur_sel = 1'b0; cur_pat = 7'h00; cur_len = 0;
        exp_upd = 0; exp_err = 0; m_ct = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.tens", 32'(tens), 32'hF);
        chk("reset.ones", 32'(ones), 32'hF);
        chk("reset.valid", 32'(valid), 32'h0);
        chk("reset.update", 32'(update), 32'h0);
        chk("reset.err", 32'(err), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        drive_phase(1'b0, 7'h00, 3);
        frames(7'h06, 7'h06, 3);
        checkpoint("ones_3frames");
        frames(7'h06, 7'h06, 2);
        checkpoint("ones_4frames");
        frames(7'h06, 7'h06, 4);
        checkpoint("ones_repeat");

        frames(7'h00, 7'h00, 6);
        checkpoint("blank");
        frames(7'h5B, 7'h3F, 6);
        checkpoint("two_zero");

        frames(7'h4F, 7'h66, 2);
        drive_phase(1'b1, 7'h01, 2);
        drive_phase(1'b0, 7'h66, 2);
        frames(7'h4F, 7'h66, 3);
        checkpoint("illegal_tens");
        frames(7'h4F, 7'h66, 3);
        checkpoint("after_illegal");

        frames(7'h6D, 7'h7D, 2);
        drive_phase(1'b1, 7'h6D, 2);
        drive_phase(1'b0, 7'h7D, 1);
        drive_phase(1'b1, 7'h7D, 1);
        drive_phase(1'b0, 7'h7D, 2);
        frames(7'h6D, 7'h7D, 2);
        checkpoint("glitch");

        drive_phase(1'b0, 7'h7D, 1100);
        checkpoint("timeout");
        frames(7'h4F, 7'h66, 5);
        checkpoint("resume");

        drive_phase(1'b1, 7'h07, 2);
        drive_phase(1'b0, 7'h7F, 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset.tens", 32'(tens), 32'hF);
        chk("midreset.ones", 32'(ones), 32'hF);
        chk("midreset.valid", 32'(valid), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        cur_len = 0;
        drive_phase(1'b0, 7'h7F, 2);
        checkpoint("after_reset");
        frames(7'h07, 7'h7F, 5);
        checkpoint("post_reset_run");

        for (int g = 0; g < 120; g++) begin
            t_i  = $urandom_range(0, 3) * 3;
            o_i  = $urandom_range(0, 3) * 3 + 1;
            reps = $urandom_range(1, 6);
            for (int r = 0; r < reps; r++) begin
                tp  = ($urandom_range(0, 29) == 0) ? 7'h01 : pat_tab[t_i];
                op  = ($urandom_range(0, 29) == 0) ? 7'h49 : pat_tab[o_i];
                len = ($urandom_range(0, 19) == 0) ? 1 : $urandom_range(2, 4);
                drive_phase(1'b1, tp, len);
                len = ($urandom_range(0, 19) == 0) ? 1 : $urandom_range(2, 4);
                drive_phase(1'b0, op, len);
            end
            if (g % 10 == 9) checkpoint("random");
        end
        checkpoint("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
